axis_pkt_gen: RTL and testbench

Parametrised AXI-Stream traffic endpoint for the mesh NoC. It generalises the fixed-pattern number generator with several additions: multi-beat packets, configurable packet count and length, and fixed or round-robin destination selection. It also has a receive side that counts packets and beats and accumulates a checksum. One instance attaches to one router port, with its master side driving the router input and its slave side accepting the router output.

---
 rtl/axis_pkt_gen.sv | 173 +++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// rtl/axis_pkt_gen.sv - AXI-Stream packet generator and receive counter for one NoC router port
module axis_pkt_gen #(
  parameter int TDATAW       = 32,
  parameter int TDESTW       = 4,
  parameter int LFSR_DW      = 8,
  parameter int LFSR_DEFAULT = 'h01,
  parameter int NUM_PACKETS  = 4,
  parameter int MAX_PKT_LEN  = 8,
  parameter int DEST_BASE    = 0,
  parameter int NUM_DESTS    = 1,
  parameter int DEST_MODE    = 0,
  parameter int LW           = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [LW-1:0]     CFG_PKT_LEN,
  input  logic              RX_STALL,
  input  logic              RX_CLEAR,
  output logic              DONE,
  output logic              BUSY,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic [15:0]       RX_PKT_CNT,
  output logic [15:0]       RX_BEAT_CNT,
  output logic [TDATAW-1:0] RX_SUM
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       beat_q, beat_d;
  logic [7:0]          pkt_q, pkt_d;
  logic [7:0]          dest_q, dest_d;
  logic [LFSR_DW-1:0]  lfsr_q, lfsr_d;
  logic                fb;
  logic                m_hs;
  logic                m_last;
  logic                s_hs;
  logic [TDESTW-1:0]   dest_val;
  logic [15:0]         rx_pkt_q, rx_beat_q;
  logic [TDATAW-1:0]   rx_sum_q;
  logic                unused_s_tdest;

  // Feedback taps of the Fibonacci LFSR, selected by payload width
  generate
    if (LFSR_DW == 16) begin : g_fb16
      assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end else begin : g_fb8
      assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end
  endgenerate

  assign m_hs   = AXIS_M_TVALID && AXIS_M_TREADY;
  assign m_last = (beat_q == len_q - LW'(1));

  // dest_q tracks pkt_idx mod NUM_DESTS incrementally, avoiding a divider
  assign dest_val = (DEST_MODE == 1) ? TDESTW'(DEST_BASE) + TDESTW'(dest_q)
                                     : TDESTW'(DEST_BASE);

  // Stream outputs are zeroed outside SEND so the port is quiet while idle
  assign AXIS_M_TVALID = (state_q == S_SEND);
  assign AXIS_M_TDATA  = AXIS_M_TVALID ? TDATAW'(lfsr_q) : '0;
  assign AXIS_M_TLAST  = AXIS_M_TVALID && m_last;
  assign AXIS_M_TDEST  = AXIS_M_TVALID ? dest_val : '0;
  assign DONE          = (state_q == S_FIN);
  assign BUSY          = (state_q != S_IDLE);

  // State and transmit-side registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      len_q   <= LW'(1);
      beat_q  <= '0;
      pkt_q   <= '0;
      dest_q  <= '0;
      lfsr_q  <= LFSR_DW'(LFSR_DEFAULT);
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      dest_q  <= dest_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Next-state logic: burst sequencing, beat/packet indices and LFSR stepping
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    dest_d  = dest_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SEND;
          beat_d  = '0;
          pkt_d   = '0;
          dest_d  = '0;
          if (CFG_PKT_LEN == '0) begin
            len_d = LW'(1);
          end else if (CFG_PKT_LEN > LW'(MAX_PKT_LEN)) begin
            len_d = LW'(MAX_PKT_LEN);
          end else begin
            len_d = CFG_PKT_LEN;
          end
        end
      end
      S_SEND: begin
        if (m_hs) begin
          lfsr_d = {lfsr_q[LFSR_DW-2:0], fb};
          if (m_last) begin
            beat_d = '0;
            pkt_d  = pkt_q + 8'd1;
            dest_d = (dest_q == 8'(NUM_DESTS - 1)) ? 8'd0 : dest_q + 8'd1;
            if (pkt_q == 8'(NUM_PACKETS - 1)) begin
              state_d = S_FIN;
            end
          end else begin
            beat_d = beat_q + LW'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Receive side is independent of the transmit FSM; tdest is not needed here
  assign AXIS_S_TREADY  = !RX_STALL && !RST;
  assign s_hs           = AXIS_S_TVALID && AXIS_S_TREADY;
  assign unused_s_tdest = ^AXIS_S_TDEST;

  // RX counters; a clear wins over a same-cycle beat, which is then dropped
  always_ff @(posedge CLK) begin
    if (RST || RX_CLEAR) begin
      rx_pkt_q  <= '0;
      rx_beat_q <= '0;
      rx_sum_q  <= '0;
    end else if (s_hs) begin
      rx_beat_q <= rx_beat_q + 16'd1;
      rx_sum_q  <= rx_sum_q + AXIS_S_TDATA;
      if (AXIS_S_TLAST) begin
        rx_pkt_q <= rx_pkt_q + 16'd1;
      end
    end
  end

  assign RX_PKT_CNT  = rx_pkt_q;
  assign RX_BEAT_CNT = rx_beat_q;
  assign RX_SUM      = rx_sum_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb/tb_axis_pkt_gen.sv - self-checking bench for axis_pkt_gen with a behavioural traffic model
module tb_axis_pkt_gen;
  localparam int TDATAW = 32;
  localparam int TDESTW = 4;
  localparam int MAXL   = 8;
  localparam int LW     = 4;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [3:0]  t;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_start, a_stall, a_clear, a_done, a_busy;
  logic [LW-1:0] a_cfg;
  logic a_mv, a_mr, a_ml, a_sv, a_sr, a_sl;
  logic [TDATAW-1:0] a_md, a_sd, a_sum;
  logic [TDESTW-1:0] a_mt, a_st;
  logic [15:0] a_pc, a_bc;
  logic b_start, b_stall, b_clear, b_done, b_busy;
  logic [LW-1:0] b_cfg;
  logic b_mv, b_mr, b_ml, b_sv, b_sr, b_sl;
  logic [TDATAW-1:0] b_md, b_sd, b_sum;
  logic [TDESTW-1:0] b_mt, b_st;
  logic [15:0] b_pc, b_bc;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] lfsr_m [2];
  beat_t expq[$];

  axis_pkt_gen #(.TDATAW(TDATAW), .TDESTW(TDESTW), .LFSR_DW(8), .LFSR_DEFAULT('h01),
    .NUM_PACKETS(2), .MAX_PKT_LEN(MAXL), .DEST_BASE(0), .NUM_DESTS(1), .DEST_MODE(0)) u_a (
    .CLK(clk), .RST(rst), .START(a_start), .CFG_PKT_LEN(a_cfg), .RX_STALL(a_stall),
    .RX_CLEAR(a_clear), .DONE(a_done), .BUSY(a_busy), .AXIS_M_TVALID(a_mv),
    .AXIS_M_TREADY(a_mr), .AXIS_M_TDATA(a_md), .AXIS_M_TLAST(a_ml), .AXIS_M_TDEST(a_mt),
    .AXIS_S_TVALID(a_sv), .AXIS_S_TREADY(a_sr), .AXIS_S_TDATA(a_sd), .AXIS_S_TLAST(a_sl),
    .AXIS_S_TDEST(a_st), .RX_PKT_CNT(a_pc), .RX_BEAT_CNT(a_bc), .RX_SUM(a_sum));

  axis_pkt_gen #(.TDATAW(TDATAW), .TDESTW(TDESTW), .LFSR_DW(8), .LFSR_DEFAULT('h01),
    .NUM_PACKETS(5), .MAX_PKT_LEN(MAXL), .DEST_BASE(1), .NUM_DESTS(3), .DEST_MODE(1)) u_b (
    .CLK(clk), .RST(rst), .START(b_start), .CFG_PKT_LEN(b_cfg), .RX_STALL(b_stall),
    .RX_CLEAR(b_clear), .DONE(b_done), .BUSY(b_busy), .AXIS_M_TVALID(b_mv),
    .AXIS_M_TREADY(b_mr), .AXIS_M_TDATA(b_md), .AXIS_M_TLAST(b_ml), .AXIS_M_TDEST(b_mt),
    .AXIS_S_TVALID(b_sv), .AXIS_S_TREADY(b_sr), .AXIS_S_TDATA(b_sd), .AXIS_S_TLAST(b_sl),
    .AXIS_S_TDEST(b_st), .RX_PKT_CNT(b_pc), .RX_BEAT_CNT(b_bc), .RX_SUM(b_sum));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Payload sequence rule: shift left, feedback from bits 7,5,4,3
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic sample(input int sel, output logic mv, output logic [31:0] md,
                        output logic ml, output logic [3:0] mt, output logic dn, output logic bz);
    if (sel == 0) begin
      mv = a_mv; md = a_md; ml = a_ml; mt = a_mt; dn = a_done; bz = a_busy;
    end else begin
      mv = b_mv; md = b_md; ml = b_ml; mt = b_mt; dn = b_done; bz = b_busy;
    end
  endtask

  task automatic drive_m(input int sel, input logic st, input int cfg, input logic rdy);
    if (sel == 0) begin
      a_start = st; a_cfg = LW'(cfg); a_mr = rdy;
    end else begin
      b_start = st; b_cfg = LW'(cfg); b_mr = rdy;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lfsr_m[0] = 8'h01;
    lfsr_m[1] = 8'h01;
  endtask

  // One START burst; bp: 0 always ready, 1 ready pattern 1-0-0-1, 2 random ready
  task automatic burst(input int sel, input int cfg, input int bp);
    int np, len, cyc;
    logic rdy, mv, ml, dn, bz;
    logic [31:0] md;
    logic [3:0] mt;
    beat_t b;
    np = (sel == 0) ? 2 : 5;
    len = (cfg == 0) ? 1 : ((cfg > MAXL) ? MAXL : cfg);
    expq.delete();
    for (int p = 0; p < np; p++) begin
      for (int k = 0; k < len; k++) begin
        b.d = 32'(lfsr_m[sel]);
        b.l = (k == len - 1);
        b.t = (sel == 0) ? 4'd0 : 4'(1 + (p % 3));
        expq.push_back(b);
        lfsr_m[sel] = lfsr_next(lfsr_m[sel]);
      end
    end
    @(negedge clk);
    drive_m(sel, 1'b1, cfg, 1'b0);
    @(negedge clk);
    drive_m(sel, 1'b0, 0, 1'b0);
    cyc = 0;
    while (expq.size() > 0 && cyc < 300) begin
      sample(sel, mv, md, ml, mt, dn, bz);
      chk("tvalid_in_send", mv, 1);
      chk("done_low_in_send", dn, 0);
      if (bp == 0) rdy = 1'b1;
      else if (bp == 1) rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else rdy = 1'($urandom_range(0, 1));
      drive_m(sel, 1'b0, 0, rdy);
      if (mv) begin
        chk("tdata", md, expq[0].d);
        chk("tlast", ml, expq[0].l);
        chk("tdest", mt, expq[0].t);
        if (rdy) void'(expq.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    chk("burst_all_beats", expq.size(), 0);
    if (bp == 0) chk("burst_cycles", cyc, np * len);
    sample(sel, mv, md, ml, mt, dn, bz);
    chk("done_pulse", dn, 1);
    chk("busy_in_fin", bz, 1);
    chk("tvalid_in_fin", mv, 0);
    drive_m(sel, 1'b0, 0, 1'b0);
    @(negedge clk);
    sample(sel, mv, md, ml, mt, dn, bz);
    chk("done_single", dn, 0);
    chk("busy_idle", bz, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rd [6];
    int rdat [6];
    int rl [6];
    int rs [6];
    int m_bc, m_pc;
    logic [31:0] m_sum;
    logic v, l, s, c;
    logic [31:0] d;

    rst = 1'b1;
    a_start = 0; a_cfg = '0; a_stall = 0; a_clear = 0; a_mr = 0; a_sv = 0; a_sd = '0; a_sl = 0; a_st = '0;
    b_start = 0; b_cfg = '0; b_stall = 0; b_clear = 0; b_mr = 0; b_sv = 0; b_sd = '0; b_sl = 0; b_st = '0;
    lfsr_m[0] = 8'h01;
    lfsr_m[1] = 8'h01;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tvalid", a_mv, 0);
    chk("rst_tdata", a_md, 0);
    chk("rst_tlast", a_ml, 0);
    chk("rst_done", a_done, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_s_tready", a_sr, 0);
    chk("rst_b_s_tready", b_sr, 0);
    chk("rst_rx_pkt", a_pc, 0);
    chk("rst_rx_beat", a_bc, 0);
    chk("rst_rx_sum", a_sum, 0);
    chk("rst_b_rx", {b_pc, b_bc} | b_sum, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tvalid", a_mv, 0);
    chk("post_rst_b_tdest", b_mt, 0);
    chk("post_rst_busy", b_busy, 0);

    // Directed receive: 5,6,7,8 with tlast on 2nd and 4th, two stalled cycles
    rd = '{1, 1, 1, 1, 1, 1};
    rdat = '{5, 6, 7, 7, 7, 8};
    rl = '{0, 1, 0, 0, 0, 1};
    rs = '{0, 0, 1, 1, 0, 0};
    m_bc = 0; m_pc = 0; m_sum = '0;
    for (int i = 0; i < 6; i++) begin
      a_sv = 1'(rd[i]); a_sd = 32'(rdat[i]); a_sl = 1'(rl[i]); a_stall = 1'(rs[i]);
      #1;
      chk("rx_tready", a_sr, !a_stall);
      if (a_sv && !a_stall) begin
        m_bc++; m_sum += a_sd; if (a_sl) m_pc++;
      end
      @(negedge clk);
      chk("rx_beat_step", a_bc, 16'(m_bc));
    end
    a_sv = 0; a_stall = 0;
    chk("rx_beat_cnt", a_bc, 4);
    chk("rx_pkt_cnt", a_pc, 2);
    chk("rx_sum", a_sum, 26);
    a_sv = 1; a_sd = 32'd9; a_sl = 1; a_clear = 1;
    @(negedge clk);
    a_sv = 0; a_clear = 0;
    chk("rx_clear_beat", a_bc, 0);
    chk("rx_clear_pkt", a_pc, 0);
    chk("rx_clear_sum", a_sum, 0);

    // Randomised receive traffic against running totals
    m_bc = 0; m_pc = 0; m_sum = '0;
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      d = $urandom;
      l = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 9) == 0);
      a_sv = v; a_sd = d; a_sl = l; a_stall = s; a_clear = c;
      if (c) begin
        m_bc = 0; m_pc = 0; m_sum = '0;
      end else if (v && !s) begin
        m_bc++; m_sum += d; if (l) m_pc++;
      end
      @(negedge clk);
      chk("rx_rand_beat", a_bc, 16'(m_bc));
      chk("rx_rand_pkt", a_pc, 16'(m_pc));
      chk("rx_rand_sum", a_sum, m_sum);
    end
    a_sv = 0; a_stall = 0; a_clear = 0;

    // Transmit bursts
    burst(0, 3, 0);
    do_reset();
    burst(0, 3, 1);
    burst(0, 0, 0);
    burst(0, 15, 0);
    burst(1, 2, 0);
    burst(1, $urandom_range(0, 15), 2);

    // Reset after the second beat of a burst abandons it without DONE
    do_reset();
    @(negedge clk);
    drive_m(0, 1'b1, 3, 1'b1);
    @(negedge clk);
    drive_m(0, 1'b0, 0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_m(0, 1'b0, 0, 1'b0);
    lfsr_m[0] = 8'h01;
    lfsr_m[1] = 8'h01;
    chk("midrst_tvalid", a_mv, 0);
    chk("midrst_busy", a_busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_done", a_done, 0);
      @(negedge clk);
    end
    burst(0, 3, 0);

    for (int i = 0; i < 4; i++) begin
      burst($urandom_range(0, 1), $urandom_range(0, 15), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
